// File: rtl/selector_sequencer.sv
// In-order result sequencer: collects tagged lane results into four holding slots,
// steps the Selector address N from 0 to SIZE-1 and streams each tag's result out in order.
module selector_sequencer #(
   parameter int  SIZE = 16,
   parameter int  K    = 8,
   localparam int A    = $clog2(SIZE),
   localparam int W    = K + A
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [3:0]   lane_valid,
   input  logic [W-1:0] lane_in0,
   input  logic [W-1:0] lane_in1,
   input  logic [W-1:0] lane_in2,
   input  logic [W-1:0] lane_in3,
   output logic [3:0]   lane_ready,
   output logic [W-1:0] sel_in0,
   output logic [W-1:0] sel_in1,
   output logic [W-1:0] sel_in2,
   output logic [W-1:0] sel_in3,
   output logic [A-1:0] N,
   input  logic [K-1:0] sel_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [K-1:0] out_data,
   output logic [A-1:0] out_tag,
   output logic         busy,
   output logic         done
);

   localparam logic [A-1:0] LAST_TAG   = A'(SIZE - 1);
   // An empty slot presents the all-ones tag with zero data so it never adds to the Selector OR.
   localparam logic [W-1:0] EMPTY_SLOT = {{A{1'b1}}, {K{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t       state_reg, state_next;
   logic [A-1:0] n_reg, n_next;
   logic [K-1:0] out_data_reg, out_data_next;
   logic [A-1:0] out_tag_reg, out_tag_next;
   logic         done_reg, done_next;
   logic         armed_reg;
   logic [3:0]   full_reg;
   logic [W-1:0] slot_reg [4];
   logic [W-1:0] lane_data [4];
   logic [W-1:0] sel_data [4];
   logic [3:0]   match;
   logic         hit;
   logic         consume;

   assign lane_data[0] = lane_in0;
   assign lane_data[1] = lane_in1;
   assign lane_data[2] = lane_in2;
   assign lane_data[3] = lane_in3;

   // Hit detection relies on the full bits, so a zero-data tag SIZE-1 still counts.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         assign match[gi]    = full_reg[gi] && (slot_reg[gi][W-1:K] == n_reg);
         assign sel_data[gi] = full_reg[gi] ? slot_reg[gi] : EMPTY_SLOT;
      end
   endgenerate

   assign sel_in0    = sel_data[0];
   assign sel_in1    = sel_data[1];
   assign sel_in2    = sel_data[2];
   assign sel_in3    = sel_data[3];
   assign hit        = |match;
   assign consume    = (state_reg == RUN) && hit;
   assign lane_ready = ~full_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_reg <= '0;
         for (int i = 0; i < 4; i++) begin
            slot_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (lane_valid[i] && !full_reg[i]) begin
               full_reg[i] <= 1'b1;
               slot_reg[i] <= lane_data[i];
            end else if (consume && match[i]) begin
               full_reg[i] <= 1'b0;
            end
         end
      end
   end

   // armed_reg masks start on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         n_reg        <= '0;
         out_data_reg <= '0;
         out_tag_reg  <= '0;
         done_reg     <= 1'b0;
         armed_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         n_reg        <= n_next;
         out_data_reg <= out_data_next;
         out_tag_reg  <= out_tag_next;
         done_reg     <= done_next;
         armed_reg    <= 1'b1;
      end
   end

   always_comb begin
      state_next    = state_reg;
      n_next        = n_reg;
      out_data_next = out_data_reg;
      out_tag_next  = out_tag_reg;
      done_next     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && armed_reg) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (hit) begin
               out_data_next = sel_result;
               out_tag_next  = n_reg;
               state_next    = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (n_reg == LAST_TAG) begin
                  n_next     = '0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  n_next     = n_reg + A'(1);
                  state_next = RUN;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign N         = n_reg;
   assign out_valid = (state_reg == OUT);
   assign out_data  = out_data_reg;
   assign out_tag   = out_tag_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;

endmodule

// File: tb/tb_selector_sequencer.sv
// Randomized bench for selector_sequencer: lanes deliver each run's tags out of order,
// a behavioural Selector answers N, and outputs are compared with a reference model.
module tb_selector_sequencer;
   localparam int SIZE = 16;
   localparam int K    = 8;
   localparam int A    = 4;
   localparam int W    = K + A;
   localparam int P_IDLE = 0, P_RUN = 1, P_OUT = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   lane_valid = '0;
   logic [W-1:0] lane_in [4];
   logic [3:0]   lane_ready;
   logic [W-1:0] sel_in [4];
   logic [A-1:0] N;
   logic [K-1:0] sel_result;
   logic         out_valid;
   logic [K-1:0] out_data;
   logic [A-1:0] out_tag;
   logic         busy;
   logic         done;

   int checks = 0;
   int failures = 0;

   // stimulus: per-lane ascending item lists for the current run
   logic [W-1:0] lane_items [4][SIZE+1];
   int           lane_cnt [4];
   int           lane_head [4];
   logic [K-1:0] run_data [SIZE];
   bit           dup_on;
   int           dup_tag, dup_a, dup_b;

   // reference model
   int           m_phase;
   logic [A-1:0] m_n;
   logic [3:0]   m_full;
   logic [W-1:0] m_item [4];
   logic [K-1:0] m_od;
   logic [A-1:0] m_ot;
   bit           m_done, m_armed;
   logic [3:0]   tr;

   always #5 clk = ~clk;

   selector_sequencer #(.SIZE(SIZE), .K(K)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lane_valid(lane_valid),
      .lane_in0(lane_in[0]), .lane_in1(lane_in[1]), .lane_in2(lane_in[2]), .lane_in3(lane_in[3]),
      .lane_ready(lane_ready),
      .sel_in0(sel_in[0]), .sel_in1(sel_in[1]), .sel_in2(sel_in[2]), .sel_in3(sel_in[3]),
      .N(N), .sel_result(sel_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .busy(busy), .done(done)
   );

   // Behavioural Selector: OR of the data of every input whose tag equals N.
   always_comb begin
      sel_result = '0;
      for (int i = 0; i < 4; i++) begin
         if (sel_in[i][W-1:K] == N) sel_result = sel_result | sel_in[i][K-1:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_n = '0; m_full = '0; m_od = '0; m_ot = '0;
      m_done = 1'b0; m_armed = 1'b0; tr = '0;
      for (int i = 0; i < 4; i++) m_item[i] = '0;
   endtask

   task automatic check_all();
      check("lane_ready", lane_ready, 4'(~m_full));
      check("out_valid", out_valid, m_phase == P_OUT);
      check("out_data", out_data, m_od);
      check("out_tag", out_tag, m_ot);
      check("N", N, m_n);
      check("busy", busy, m_phase != P_IDLE);
      check("done", done, m_done);
      for (int i = 0; i < 4; i++)
         check("sel_in", sel_in[i], m_full[i] ? m_item[i] : {4'hF, 8'h00});
   endtask

   // Predict the coming clock edge from the inputs now applied, then advance one cycle and compare.
   task automatic step();
      logic [3:0]   hitm;
      logic [K-1:0] acc;
      bit           nd;
      nd = 1'b0;
      tr = lane_valid & ~m_full;
      case (m_phase)
         P_IDLE: if (start && m_armed) m_phase = P_RUN;
         P_RUN: begin
            hitm = '0; acc = '0;
            for (int i = 0; i < 4; i++) begin
               if (m_full[i] && m_item[i][W-1:K] == m_n) begin
                  hitm[i] = 1'b1;
                  acc = acc | m_item[i][K-1:0];
               end
            end
            if (hitm != 0) begin
               m_od = acc; m_ot = m_n; m_full = m_full & ~hitm; m_phase = P_OUT;
            end
         end
         default: begin
            if (out_ready) begin
               if (m_n == SIZE - 1) begin
                  m_n = '0; nd = 1'b1; m_phase = P_IDLE;
               end else begin
                  m_n = m_n + 1'b1; m_phase = P_RUN;
               end
            end
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         if (tr[i]) begin m_full[i] = 1'b1; m_item[i] = lane_in[i]; end
      end
      m_done = nd; m_armed = 1'b1;
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
         if (tr[l]) begin lane_head[l]++; lane_valid[l] = 1'b0; end
      end
      check_all();
   endtask

   task automatic push(input int l, input int t, input logic [K-1:0] d);
      lane_items[l][lane_cnt[l]] = {4'(t), d};
      lane_cnt[l]++;
      run_data[t] = run_data[t] | d;
   endtask

   task automatic gen_run(input int r);
      logic [K-1:0] d;
      int l, l2;
      dup_on  = (r == 2) || (r >= 4 && $urandom_range(0, 1) == 1);
      dup_tag = (r == 2) ? 5 : $urandom_range(0, SIZE - 2);
      for (int i = 0; i < 4; i++) begin lane_cnt[i] = 0; lane_head[i] = 0; end
      for (int t = 0; t < SIZE; t++) run_data[t] = '0;
      for (int t = 0; t < SIZE; t++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 5) == 0 || (r == 0 && t == SIZE - 1)) d = '0;
         if (r == 2 && t == 5) d = 8'h0F;
         l = (r == 0) ? t % 4 : $urandom_range(0, 3);
         push(l, t, d);
         if (dup_on && t == dup_tag) begin
            l2 = (l + 1 + $urandom_range(0, 2)) % 4;
            dup_a = l; dup_b = l2;
            push(l2, t, (r == 2) ? 8'h0F << 4 : 8'($urandom));
         end
      end
   endtask

   // Lanes offer their next item at random; both copies of a duplicated tag are offered together.
   task automatic drive_lanes();
      logic [W-1:0] it;
      bit go;
      int o;
      for (int l = 0; l < 4; l++) begin
         if (!lane_valid[l] && lane_head[l] < lane_cnt[l]) begin
            it = lane_items[l][lane_head[l]];
            if (dup_on && it[W-1:K] == 4'(dup_tag) && (l == dup_a || l == dup_b)) begin
               o  = (l == dup_a) ? dup_b : dup_a;
               go = (lane_head[o] < lane_cnt[o]) && (lane_items[o][lane_head[o]][W-1:K] == 4'(dup_tag));
            end else begin
               go = $urandom_range(0, 1) == 1;
            end
            if (go) begin lane_valid[l] = 1'b1; lane_in[l] = it; end
         end
      end
   endtask

   task automatic mid_reset();
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; lane_valid = '0;
      for (int l = 0; l < 4; l++) lane_head[l] = lane_cnt[l];
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      check_all();
      rst_n = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run(input int r);
      int cyc, ocnt, exp_tag;
      gen_run(r);
      exp_tag = 0; ocnt = 0; cyc = 0;
      start = 1'b1; drive_lanes(); out_ready = 1'b1;
      step();
      start = 1'b0;
      while (!m_done && cyc < 3000) begin
         drive_lanes();
         ocnt      = (m_phase == P_OUT) ? ocnt + 1 : 0;
         out_ready = (r == 1) ? (ocnt > 5) : ($urandom_range(0, 3) != 0);
         start     = $urandom_range(0, 7) == 0;
         if (r == 3 && exp_tag == 6 && m_phase == P_OUT) begin
            mid_reset();
            return;
         end
         if (m_phase == P_OUT && out_ready) begin
            $display("run %0d out tag=%0d data=%02h", r, out_tag, out_data);
            check("hs_tag", out_tag, exp_tag);
            check("hs_data", out_data, run_data[exp_tag]);
            exp_tag++;
         end
         step();
         cyc++;
      end
      check("run_complete", exp_tag, SIZE);
   endtask

   initial begin
      for (int l = 0; l < 4; l++) lane_in[l] = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int r = 0; r < 8; r++) run(r);
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/selector_sequencer.md
# selector_sequencer

In-order result sequencer that feeds and controls the 4-input tag `Selector`. It accepts tagged results, each carrying `{tag, data}`, from four independent lanes into holding slots, and drives those slots and the address `N` into the `Selector`. It steps `N` from 0 to SIZE-1 and emits each tag's data on a valid/ready output stream, releasing the consumed slots back to their lanes. It sits between the processing lanes and the downstream consumer, turning out-of-order lane completions into an ordered stream.

## Interface
- `SIZE`, 16: number of tags per run; tag width A = $clog2(SIZE).
- `K`, 8: data width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a run; sampled only in IDLE.
- `lane_valid`  in  4: lane i offers `lane_in{i}`.
- `lane_in0..lane_in3`  in  K+A each: `{tag[A-1:0], data[K-1:0]}`, tag in the MSBs.
- `lane_ready`  out  4: slot i empty; a transfer occurs when `lane_valid[i] & lane_ready[i]`.
- `sel_in0..sel_in3`  out  K+A each: slot contents to the Selector. An empty slot drives all-ones tag and zero data, so it is never matched for any N < SIZE-1. The empty-slot data field is 0, so it contributes nothing to the OR.
- `N`  out  A: current tag to the Selector.
- `sel_result`  in  K: Selector `final_result`, combinational from `sel_in*` and `N`.
- `out_valid`  out  1: `out_data` holds the result for tag `out_tag`.
- `out_ready`  in  1: consumer accepts.
- `out_data`  out  K; `out_tag`  out  A.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse after the last tag is accepted.

## Operation
- Slots: per lane, a `full` bit plus a K+A register. A slot loads on a lane transfer in any state and clears only on consumption.
- Hit: `hit` is high when some full slot's tag equals `N`. The comparison uses the `full` bits; the Selector's result alone does not count as a hit. This makes tag SIZE-1 with zero data work correctly.
- FSM states:
  - IDLE: `N`=0. On `start`, go to RUN.
  - RUN: if `hit`, latch `out_data`<=`sel_result` and `out_tag`<=`N`, clear every full slot whose tag equals `N`, set `out_valid`, and go to OUT. Otherwise stay in RUN and wait indefinitely.
  - OUT: hold `out_valid`, `out_data` and `out_tag` stable until `out_ready`. On the handshake:
    - if `N`==SIZE-1: `N`<=0, pulse `done`, go to IDLE;
    - else: `N`<=N+1, go to RUN.
- Duplicate tags in several slots: all matching slots are consumed together, and the output is their bitwise OR, as the Selector computes it.
- Slots whose tag is less than the current `N`, i.e. late arrivals, are never emitted in this run. They stay full and are matched in the next run.
- `N` never wraps inside a run. SIZE need not be a power of two: the last tag is SIZE-1.

## Timing
- Reset values: `lane_ready`=4'b1111, `N`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `busy`=0, `done`=0, all slots empty, state IDLE.
- `lane_ready[i]` = ~`full[i]`, a registered-bit decode with no combinational path from `lane_valid`.
- A slot cleared on the RUN->OUT edge shows `lane_ready` high in the first OUT cycle. It can be refilled during OUT, and the new content is compared in the next RUN cycle.
- Latency:
  - lane transfer at edge t with tag == `N` while in RUN: `out_valid` rises at edge t+1;
  - back-to-back tags already resident: one output every 2 cycles when `out_ready` is held high.
- `start` in any state other than IDLE is ignored. `start` in the same cycle as reset release is ignored.
- `done` is asserted in the first IDLE cycle after the final handshake. `busy` is low in that same cycle.
- `rst_n` low mid-run: everything returns to reset values immediately, in-flight slot data is discarded, and any `out_valid` is dropped without a handshake.

## Test plan
- Ordered fill, SIZE=16, K=8: lane t%4 sends {t, 8'hA0+t} as soon as `lane_ready` is high, with `out_ready`=1 → outputs tags 0..15 in order with data A0..AF, then one `done` pulse.
- Out-of-order: lanes 0..3 send tags 3,2,1,0 with data 11,22,33,44 → output order is 44,33,22,11. Each `lane_ready[i]` rises the cycle after its tag is emitted.
- Backpressure: hold `out_ready`=0 for 5 cycles in OUT → `out_valid`, `out_data` and `N` stay constant. Accept on cycle 6 → `N` increments.
- Duplicate tag: lanes 0 and 2 both send tag 5, with data 8'h0F and 8'hF0 → a single output for tag 5 with data 8'hFF, and both slots freed.
- Last tag with zero data: tag 15 with data 8'h00 → emitted with `out_tag`=15 and data 0, then `done`. There is no hang.
- Reset mid-run: assert `rst_n` low while in OUT with 3 slots full → all outputs return to reset values and `lane_ready`=1111. A new `start` begins again at `N`=0.
